// File: rtl/dmem_pkg.sv
// Shared types and funct3 codes for the data-memory controller.
package dmem_pkg;

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} dmem_state_e;

    typedef enum logic {GNT_CPU, GNT_LD} dmem_grant_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // log2 of the access width in bytes; unlisted codes behave as words
    function automatic logic [1:0] size_log2(input logic [2:0] size);
        if (size == F3_B || size == F3_BU) begin
            return 2'd0;
        end else if (size == F3_H || size == F3_HU) begin
            return 2'd1;
        end
        return 2'd2;
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte/halfword lane handling: store merge into an old word and load extension.
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] data_i,
    input  logic [2:0]  size_i,
    input  logic [1:0]  off_i,
    output logic [31:0] merged_o,
    output logic [31:0] load_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sext;

    always_comb begin
        byte_sel = word_i[{off_i, 3'b000} +: 8];
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
        sext     = ~size_i[2];
        merged_o = word_i;
        load_o   = word_i;
        case (size_log2(size_i))
            2'd0: begin
                merged_o[{off_i, 3'b000} +: 8] = data_i[7:0];
                load_o = {{24{byte_sel[7] & sext}}, byte_sel};
            end
            2'd1: begin
                if (off_i[1]) begin
                    merged_o[31:16] = data_i[15:0];
                end else begin
                    merged_o[15:0] = data_i[15:0];
                end
                load_o = {{16{half_sel[15] & sext}}, half_sel};
            end
            default: begin
                merged_o = data_i;
                load_o   = word_i;
            end
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Round-robin data-memory controller with read-modify-write sub-word stores.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned accesses report err instead of being masked.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [2:0]  cpu_size,
    input  logic [31:0] cpu_wData,
    output logic        cpu_ready,
    output logic [31:0] cpu_rData,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_wData,
    output logic        ld_ready,
    output logic [31:0] ld_rData,
    output logic        err,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wData,
    input  logic [31:0] ram_rData
);

    localparam int unsigned AW = $clog2(DEPTH);

    dmem_state_e state_q, state_d;
    dmem_grant_e gnt_q, gnt_d, last_q, last_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, word_q, word_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d, ld_rdata_q, ld_rdata_d;
    logic [2:0]  size_q, size_d;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        err_q, err_d;
    logic        sel_misal;
`endif

    logic        pick_cpu, pick_any, sel_we, trap;
    logic [31:0] sel_addr, sel_addr_al, sel_wdata;
    logic [2:0]  sel_size;
    logic [1:0]  sel_lg;
    logic [31:0] fmt_merged, fmt_load;

    logic unused_addr;
    assign unused_addr = ^addr_q[31:AW+2];

    dmem_lane_fmt u_lane_fmt (
        .word_i   (ram_rData),
        .data_i   (wdata_q),
        .size_i   (size_q),
        .off_i    (addr_q[1:0]),
        .merged_o (fmt_merged),
        .load_o   (fmt_load)
    );

    // CPU wins unless the loader also asks and the CPU had the previous grant.
    always_comb begin
        pick_cpu    = cpu_req && (!ld_req || last_q == GNT_LD);
        pick_any    = cpu_req || ld_req;
        sel_we      = pick_cpu ? cpu_we : ld_we;
        sel_addr    = pick_cpu ? cpu_addr : ld_addr;
        sel_wdata   = pick_cpu ? cpu_wData : ld_wData;
        sel_size    = pick_cpu ? cpu_size : F3_W;
        sel_lg      = size_log2(sel_size);
        sel_addr_al = sel_addr;
`ifdef DMEM_MISALIGN_TRAP_EN
        sel_misal = (sel_lg == 2'd1 && sel_addr[0]) ||
                    (sel_lg == 2'd2 && sel_addr[1:0] != 2'b00);
        trap      = sel_misal;
`else
        trap = 1'b0;
        if (sel_lg == 2'd1) begin
            sel_addr_al[0] = 1'b0;
        end else if (sel_lg == 2'd2) begin
            sel_addr_al[1:0] = 2'b00;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (pick_any) begin
                    if (trap) begin
                        state_d = StDone;
                    end else if (sel_we && sel_lg == 2'd2) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead:  state_d = we_q ? StWrite : StDone;
            StWrite: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        gnt_d       = gnt_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        word_d      = word_q;
        cpu_rdata_d = cpu_rdata_q;
        ld_rdata_d  = ld_rdata_q;
`ifdef DMEM_MISALIGN_TRAP_EN
        err_d       = err_q;
`endif
        if (state_q == StIdle && pick_any) begin
            gnt_d   = pick_cpu ? GNT_CPU : GNT_LD;
            last_d  = gnt_d;
            we_d    = sel_we;
            addr_d  = sel_addr_al;
            size_d  = sel_size;
            wdata_d = sel_wdata;
`ifdef DMEM_MISALIGN_TRAP_EN
            err_d   = trap;
`endif
            // word_q doubles as the write buffer, so full-word stores skip READ
            if (sel_we && sel_lg == 2'd2 && !trap) begin
                word_d = sel_wdata;
            end
        end
        if (state_q == StRead) begin
            if (we_q) begin
                word_d = fmt_merged;
            end else if (gnt_q == GNT_CPU) begin
                cpu_rdata_d = fmt_load;
            end else begin
                ld_rdata_d = fmt_load;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q       <= GNT_CPU;
            last_q      <= GNT_LD;
            we_q        <= 1'b0;
            addr_q      <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
            word_q      <= '0;
            cpu_rdata_q <= '0;
            ld_rdata_q  <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
            err_q       <= 1'b0;
`endif
        end else begin
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            word_q      <= word_d;
            cpu_rdata_q <= cpu_rdata_d;
            ld_rdata_q  <= ld_rdata_d;
`ifdef DMEM_MISALIGN_TRAP_EN
            err_q       <= err_d;
`endif
        end
    end

    always_comb begin
        ram_we    = (state_q == StWrite) && !reset;
        ram_addr  = {{(32 - AW){1'b0}}, addr_q[AW+1:2]};
        ram_wData = word_q;
        cpu_ready = (state_q == StDone) && (gnt_q == GNT_CPU) && !reset;
        ld_ready  = (state_q == StDone) && (gnt_q == GNT_LD) && !reset;
        cpu_rData = cpu_rdata_q;
        ld_rData  = ld_rdata_q;
`ifdef DMEM_MISALIGN_TRAP_EN
        err = (state_q == StDone) && err_q && !reset;
`else
        err = 1'b0;
`endif
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed vector table, arbitration and reset
// sequences, then random accesses against a byte-arithmetic memory model.
`timescale 1ns/1ps
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int unsigned DEPTH = 64;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, ld_req, ld_we;
    logic [31:0] cpu_addr, cpu_wData, ld_addr, ld_wData;
    logic [2:0]  cpu_size;
    logic        cpu_ready, ld_ready, err, ram_we;
    logic [31:0] cpu_rData, ld_rData, ram_addr, ram_wData, ram_rData;

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_size  (cpu_size),
        .cpu_wData (cpu_wData),
        .cpu_ready (cpu_ready),
        .cpu_rData (cpu_rData),
        .ld_req    (ld_req),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_wData  (ld_wData),
        .ld_ready  (ld_ready),
        .ld_rData  (ld_rData),
        .err       (err),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wData (ram_wData),
        .ram_rData (ram_rData)
    );

    // RAM: combinational read, synchronous write
    logic [31:0] mem [DEPTH];
    logic [31:0] last_w = '0;
    int          wr_cnt = 0;
    assign ram_rData = mem[ram_addr[5:0]];
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr[5:0]] <= ram_wData;
            last_w <= ram_wData;
            wr_cnt <= wr_cnt + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: memory as words, accesses computed with byte arithmetic.
    logic [31:0] model_mem [DEPTH];
    logic [31:0] prev_rd [2];

    task automatic model_op(input bit port, input bit we, input logic [31:0] addr,
                            input logic [2:0] size, input logic [31:0] wd,
                            output logic [31:0] rd, output int lat, output bit e);
        int unsigned sz, idx, off;
        logic [31:0] a;
        logic [63:0] m, v;
        logic [2:0]  s;
        s = port ? 3'b010 : size;
        case (s)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            default:    sz = 4;
        endcase
        e  = 1'b0;
        rd = prev_rd[port];
        if (TRAP && (addr % sz) != 0) begin
            lat = 1;
            e   = 1'b1;
            return;
        end
        a   = addr - (addr % sz);
        idx = (a / 4) % DEPTH;
        off = a % 4;
        m   = (64'd1 << (8 * sz)) - 1;
        if (we) begin
            model_mem[idx] = 32'(({32'd0, model_mem[idx]} & ~(m << (8 * off))) |
                                 ((64'(wd) & m) << (8 * off)));
            lat = (sz == 4) ? 2 : 3;
        end else begin
            v = (64'(model_mem[idx]) >> (8 * off)) & m;
            if ((s == 3'd0 || s == 3'd1) && v[8 * sz - 1]) v = v | ~m;
            rd = v[31:0];
            prev_rd[port] = rd;
            lat = 2;
        end
    endtask

    // Issue one access from IDLE; returns latency in cycles (-1 on timeout).
    task automatic do_acc(input bit port, input bit we, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat, output bit e);
        if (port) begin
            ld_req = 1'b1; ld_we = we; ld_addr = addr; ld_wData = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_size = size; cpu_wData = wd;
        end
        lat = -1;
        rd  = '0;
        e   = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (port ? ld_ready : cpu_ready) begin
                lat = c;
                rd  = port ? ld_rData : cpu_rData;
                e   = err;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        ld_req  = 1'b0;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        cpu_req = 1'b0;
        ld_req  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        prev_rd[0] = '0;
        prev_rd[1] = '0;
        @(negedge clk);
        check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("rst_ld_ready", 32'(ld_ready), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_cpu_rData", cpu_rData, 32'd0);
        check("rst_ld_rData", ld_rData, 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_ram_wData", ram_wData, 32'd0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          exp_lat;
        bit          exp_err;
        int          exp_nw;
        logic [31:0] exp_w;
        string       name;
    } vec_t;

    vec_t tbl [21];

    initial begin
        logic [31:0] rd, mrd;
        int          lat, mlat, w0, n_seen;
        bit          e, me, seen;
        bit          order [3];

        cpu_we = 0; cpu_addr = 0; cpu_size = 0; cpu_wData = 0;
        ld_we = 0; ld_addr = 0; ld_wData = 0;
        do_reset();

        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] d;
            d = $urandom;
            model_op(1'b1, 1'b1, 32'(i * 4), F3_W, d, mrd, mlat, me);
            do_acc(1'b1, 1'b1, 32'(i * 4), F3_W, d, rd, lat, e);
        end
        check("preload_word0", mem[0], model_mem[0]);

        tbl[0]  = '{1, 1, 32'h10,  F3_W,  32'hFFFFFFFF, 32'h0,        2, 0, 1, 32'hFFFFFFFF, "ld_sw_w4"};
        tbl[1]  = '{0, 0, 32'h10,  F3_B,  32'h0,        32'hFFFFFFFF, 2, 0, 0, 32'h0, "lb_10"};
        tbl[2]  = '{0, 0, 32'h10,  F3_BU, 32'h0,        32'h000000FF, 2, 0, 0, 32'h0, "lbu_10"};
        tbl[3]  = '{0, 0, 32'h12,  F3_HU, 32'h0,        32'h0000FFFF, 2, 0, 0, 32'h0, "lhu_12"};
        tbl[4]  = '{0, 1, 32'h11,  F3_B,  32'h00000012, 32'h0000FFFF, 3, 0, 1, 32'hFFFF12FF, "sb_11"};
        tbl[5]  = '{0, 0, 32'h10,  F3_W,  32'h0,        32'hFFFF12FF, 2, 0, 0, 32'h0, "lw_10"};
        tbl[6]  = '{0, 0, 32'h10,  F3_H,  32'h0,        32'h000012FF, 2, 0, 0, 32'h0, "lh_10"};
        tbl[7]  = '{0, 0, 32'h12,  F3_H,  32'h0,        32'hFFFFFFFF, 2, 0, 0, 32'h0, "lh_12"};
        tbl[8]  = '{0, 0, 32'h11,  F3_B,  32'h0,        32'h00000012, 2, 0, 0, 32'h0, "lb_11"};
        tbl[9]  = '{0, 1, 32'h12,  F3_H,  32'h0000ABCD, 32'h00000012, 3, 0, 1, 32'hABCD12FF, "sh_12"};
        tbl[10] = '{0, 0, 32'h10,  F3_W,  32'h0,        32'hABCD12FF, 2, 0, 0, 32'h0, "lw_10b"};
        tbl[11] = '{1, 1, 32'h0C,  F3_W,  32'h11223344, 32'h0,        2, 0, 1, 32'h11223344, "ld_sw_0c"};
        tbl[12] = '{0, 0, 32'h0C,  F3_W,  32'h0,        32'h11223344, 2, 0, 0, 32'h0, "lw_0c"};
        tbl[13] = '{1, 1, 32'h100, F3_W,  32'hCAFEF00D, 32'h0,        2, 0, 1, 32'hCAFEF00D, "ld_sw_wrap"};
        tbl[14] = '{1, 0, 32'h100, F3_W,  32'h0,        32'hCAFEF00D, 2, 0, 0, 32'h0, "ld_lw_wrap"};
        tbl[15] = '{0, 0, 32'h00,  F3_W,  32'h0,        32'hCAFEF00D, 2, 0, 0, 32'h0, "lw_00"};
        tbl[16] = '{1, 1, 32'h04,  F3_W,  32'h01020304, 32'hCAFEF00D, 2, 0, 1, 32'h01020304, "ld_sw_04"};
        tbl[17] = '{0, 1, 32'h06,  F3_W,  32'h55AA55AA, 32'hCAFEF00D, TRAP ? 1 : 2, TRAP,
                    TRAP ? 0 : 1, 32'h55AA55AA, "sw_mis_06"};
        tbl[18] = '{0, 0, 32'h04,  F3_W,  32'h0, TRAP ? 32'h01020304 : 32'h55AA55AA, 2, 0, 0,
                    32'h0, "lw_04"};
        tbl[19] = '{0, 0, 32'h13,  F3_HU, 32'h0, TRAP ? 32'h01020304 : 32'h0000ABCD,
                    TRAP ? 1 : 2, TRAP, 0, 32'h0, "lhu_mis_13"};
        tbl[20] = '{0, 0, 32'h10,  3'b111, 32'h0,       32'hABCD12FF, 2, 0, 0, 32'h0, "lw_code7"};

        foreach (tbl[i]) begin
            w0 = wr_cnt;
            model_op(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].wd, mrd, mlat, me);
            do_acc(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].wd, rd, lat, e);
            check({tbl[i].name, "_lat"}, 32'(lat), 32'(tbl[i].exp_lat));
            check({tbl[i].name, "_rd"}, rd, tbl[i].exp_rd);
            check({tbl[i].name, "_err"}, 32'(e), 32'(tbl[i].exp_err));
            check({tbl[i].name, "_nwr"}, 32'(wr_cnt - w0), 32'(tbl[i].exp_nw));
            check({tbl[i].name, "_ram_addr"}, ram_addr, (tbl[i].addr >> 2) % DEPTH);
            if (tbl[i].exp_nw > 0) check({tbl[i].name, "_wdata"}, last_w, tbl[i].exp_w);
        end

        for (int i = 0; i < 150; i++) begin
            bit          p, we;
            logic [31:0] a, d;
            logic [2:0]  s;
            p  = ($urandom_range(3, 0) == 0);
            we = $urandom_range(1, 0) == 1;
            a  = $urandom_range(255, 0);
            s  = 3'($urandom_range(7, 0));
            d  = $urandom;
            w0 = wr_cnt;
            model_op(p, we, a, s, d, mrd, mlat, me);
            do_acc(p, we, a, s, d, rd, lat, e);
            check("rnd_lat", 32'(lat), 32'(mlat));
            check("rnd_rd", rd, mrd);
            check("rnd_err", 32'(e), 32'(me));
            check("rnd_nwr", 32'(wr_cnt - w0), (we && !me) ? 32'd1 : 32'd0);
        end

        // Both requesters held: after reset the CPU wins, then grants alternate.
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; cpu_size = F3_W;
        ld_req  = 1; ld_we  = 0; ld_addr  = 32'h0C;
        n_seen = 0;
        for (int c = 0; c < 30 && n_seen < 3; c++) begin
            @(negedge clk);
            if (cpu_ready || ld_ready) begin
                order[n_seen] = ld_ready;
                model_op(ld_ready, 1'b0, ld_ready ? 32'h0C : 32'h10, F3_W, 32'h0, mrd, mlat, me);
                check("arb_rd", ld_ready ? ld_rData : cpu_rData, mrd);
                n_seen++;
            end
            @(posedge clk);
            #1;
            if (n_seen == 3) begin
                cpu_req = 0;
                ld_req  = 0;
            end
        end
        cpu_req = 0;
        ld_req  = 0;
        check("arb_count", 32'(n_seen), 32'd3);
        check("arb_first_cpu", 32'(order[0]), 32'd0);
        check("arb_second_ld", 32'(order[1]), 32'd1);
        check("arb_third_cpu", 32'(order[2]), 32'd0);

        // Reset during the WRITE cycle of a full-word store.
        w0 = wr_cnt;
        seen = 1'b0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h08; cpu_size = F3_W; cpu_wData = 32'hDEADBEEF;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset   = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        check("rstwr_ram_we", 32'(ram_we), 32'd0);
        seen = seen | cpu_ready | err;
        @(posedge clk);
        #1;
        reset = 1'b0;
        prev_rd[0] = '0;
        prev_rd[1] = '0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | cpu_ready | ld_ready | err;
        end
        @(posedge clk);
        #1;
        check("rstwr_no_ready", 32'(seen), 32'd0);
        check("rstwr_no_write", 32'(wr_cnt - w0), 32'd0);
        model_op(1'b0, 1'b0, 32'h08, F3_W, 32'h0, mrd, mlat, me);
        do_acc(1'b0, 1'b0, 32'h08, F3_W, 32'h0, rd, lat, e);
        check("rstwr_old_data", rd, mrd);
        check("rstwr_lw_lat", 32'(lat), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
